// File: rtl/cdma_pkg.sv
// cdma_pkg: AXI encodings, the FSM state type and a burst-sizing helper.
// The read engine and the write engine both import this package.
package cdma_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2,
    ST_FIN  = 2'd3
  } cdma_state_e;

  // Beats for the next burst: the smallest of the burst cap, the words still
  // to read, and the words left before the next 4KB boundary.
  function automatic logic [4:0] calc_beats(input logic [9:0]  word_off,
                                            input logic [15:0] rem,
                                            input logic [4:0]  max_b);
    logic [10:0] room;
    logic [4:0]  b;
    room = 11'd1024 - {1'b0, word_off};
    b    = max_b;
    if (rem < {11'd0, b}) b = rem[4:0];
    if (room < {6'd0, b}) b = room[4:0];
    return b;
  endfunction

endpackage

// File: rtl/cdma_rslice.sv
// cdma_rslice: one-entry registered valid/ready slice.
//   in_data/in_vld/in_rdy    : upstream side; in_rdy is high when empty or draining
//   out_data/out_vld/out_rdy : downstream side, driven from flops
// A new entry may be loaded in the same cycle the old one is taken, so a
// continuous stream passes without bubbles.
module cdma_rslice #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);

  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/cdma_rd_eng.sv
// cdma_rd_eng: AXI read engine; fetches len_words 32-bit words from src_addr
// as INCR bursts (one outstanding) and streams them downstream.
//   clk, rstn                  : clock, synchronous active-low reset
//   start, src_addr, len_words : job request (start ignored while busy)
//   busy, done, err            : status; done is a 1-cycle pulse, err is sticky
//   ar*                        : AXI read address channel (master)
//   r*                         : AXI read data channel (rid is ignored)
//   dout, dout_last, dout_vld, dout_rdy : downstream word stream
//
// state   | meaning
// IDLE    | waiting for start
// AR      | address presented, waiting for arready
// RD      | receiving the beats of the outstanding burst
// FIN     | draining the last word downstream; done when drained
module cdma_rd_eng
  import cdma_pkg::*;
#(
  parameter int         MAX_BURST = 16,
  parameter logic [3:0] RD_ID     = 4'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] dout,
  output logic        dout_last,
  output logic        dout_vld,
  input  logic        dout_rdy
);

  localparam logic [4:0] MAX_B = 5'(MAX_BURST);

  cdma_state_e state;
  logic [31:0] addr_q;
  logic [15:0] rem_q;
  logic [3:0]  arlen_q;
  logic [3:0]  beat_cnt;
  logic        err_q;

  logic [4:0]  beats;
  logic [4:0]  first_beats;
  logic [4:0]  next_beats;
  logic        r_hs;
  logic        beat_last;
  logic        beat_bad;
  logic        word_last;
  logic        sl_in_rdy;
  logic [32:0] sl_out;

  assign beats       = {1'b0, arlen_q} + 5'd1;
  assign first_beats = calc_beats(src_addr[11:2], len_words, MAX_B);
  assign next_beats  = calc_beats(addr_q[11:2], rem_q, MAX_B);

  assign r_hs      = rvalid & rready;
  assign beat_last = (beat_cnt == arlen_q);
  assign beat_bad  = (rresp != AXI_RESP_OKAY) | (rlast != beat_last);
  // rem_q already excludes the current burst, so zero means this burst is the tail.
  assign word_last = beat_last & (rem_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      arlen_q  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= {src_addr[31:2], 2'b00};
            rem_q    <= len_words;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            arlen_q  <= 4'(first_beats - 5'd1);
            state    <= (len_words == 16'd0) ? ST_FIN : ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            addr_q   <= addr_q + {25'd0, beats, 2'b00};
            rem_q    <= rem_q - {11'd0, beats};
            beat_cnt <= '0;
            state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (r_hs) begin
            if (beat_bad) err_q <= 1'b1;
            if (beat_last) begin
              // Any error in the job stops further bursts once this one drains.
              if ((rem_q == 16'd0) || err_q || beat_bad) begin
                state <= ST_FIN;
              end else begin
                arlen_q <= 4'(next_beats - 5'd1);
                state   <= ST_AR;
              end
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        ST_FIN: begin
          if (!dout_vld) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cdma_rslice #(.W(33)) u_rslice (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  ({word_last, rdata}),
    .in_vld   (rvalid & (state == ST_RD)),
    .in_rdy   (sl_in_rdy),
    .out_data (sl_out),
    .out_vld  (dout_vld),
    .out_rdy  (dout_rdy)
  );

  assign dout      = sl_out[31:0];
  assign dout_last = sl_out[32];

  assign rready  = (state == ST_RD) & sl_in_rdy;
  assign arvalid = (state == ST_AR);
  assign araddr  = addr_q;
  assign arlen   = arlen_q;
  assign arid    = RD_ID;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'b000;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN) & ~dout_vld;
  assign err  = err_q;

  logic unused_ok;
  assign unused_ok = ^{rid, src_addr[1:0]};

endmodule

// File: tb/tb_cdma_rd_eng.sv
// tb_cdma_rd_eng: randomized bench for cdma_rd_eng. The bench plays the AXI
// slave and the downstream sink; expected bursts come from a plain-arithmetic
// burst planner and expected words from a queue filled as beats are served.
module tb_cdma_rd_eng;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic [31:0] src_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic [3:0]  arid, arlen, arcache, rid;
  logic [31:0] araddr, rdata, dout;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        dout_last, dout_vld, dout_rdy;

  always #5 clk = ~clk;

  cdma_rd_eng #(.MAX_BURST(16), .RD_ID(4'h0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src_addr(src_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dout(dout), .dout_last(dout_last), .dout_vld(dout_vld), .dout_rdy(dout_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int unsigned exp_ar_addr[$];
  int unsigned exp_ar_len[$];
  logic [32:0] exp_q[$];

  // Split a job into bursts: at most 16 words, never past a 4KB page end.
  function automatic void plan_bursts(input logic [31:0] a0, input int len);
    int unsigned a;
    int rem, room, b;
    a   = a0 & 32'hFFFF_FFFC;
    rem = len;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    while (rem > 0) begin
      room = int'((4096 - (a % 4096)) / 4);
      b    = 16;
      if (rem < b)  b = rem;
      if (room < b) b = room;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(b - 1);
      a   = a + 4 * b;
      rem = rem - b;
    end
  endfunction

  task automatic run_xfer(input logic [31:0] a0, input int len, input int ar_pct,
                          input int rv_pct, input int rdy_pct, input int bad_resp,
                          input int bad_last, input bit busy_start, input int abort_cyc,
                          input int exp_done_cyc);
    int ar_idx = 0, beats_left = 0, pushed = 0, popped = 0;
    int last_hs = -1, cyc = 0, err_burst = -1, done_cnt = 0, done_cyc = 0, n_allowed;
    bit exp_err = 1'b0, r_taken = 1'b0, finished = 1'b0;
    logic [32:0] e;

    plan_bursts(a0, len);
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; src_addr = a0; len_words = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;

    while (!finished && cyc < 3000) begin
      // drive this cycle's inputs
      if (r_taken) begin rvalid = 1'b0; r_taken = 1'b0; end
      if (!rvalid && beats_left > 0 && $urandom_range(99) < rv_pct) begin
        rvalid = 1'b1;
        rdata  = $urandom;
        rid    = 4'($urandom);
        rresp  = (pushed == bad_resp) ? 2'b10 : 2'b00;
        rlast  = (beats_left == 1) ^ (pushed == bad_last);
      end
      if (rdy_pct == 0) dout_rdy = (cyc % 3 == 0);
      else              dout_rdy = ($urandom_range(99) < rdy_pct);
      arready = ($urandom_range(99) < ar_pct);
      if (busy_start && cyc == 6 && popped < len) begin
        start = 1'b1; src_addr = $urandom; len_words = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rstn = 1'b0; rvalid = 1'b0; arready = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_ctl", {busy, done, err, arvalid, rready, dout_vld, dout_last}, 7'd0);
        check_eq("abort_addr", {araddr, arlen}, 36'd0);
        check_eq("abort_dout", dout, 32'd0);
        rstn = 1'b1;
        finished = 1'b1;
        break;
      end
      #1;
      n_allowed = (err_burst >= 0) ? err_burst + 1 : exp_ar_addr.size();

      // observe and update the model
      if (dout_vld && !dout_rdy) check_eq("rready_full", rready, 1'b0);
      if (arvalid) begin
        check_eq("ar_allowed", ar_idx < n_allowed, 1'b1);
        check_eq("ar_const", {arid, arsize, arburst, arlock, arcache, arprot},
                 {4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
        if (ar_idx < exp_ar_addr.size()) begin
          check_eq("araddr", araddr, exp_ar_addr[ar_idx]);
          check_eq("arlen", arlen, exp_ar_len[ar_idx]);
          if (arready) begin
            beats_left = exp_ar_len[ar_idx] + 1;
            ar_idx++;
          end
        end
      end
      if (rvalid && rready) begin
        exp_q.push_back({pushed == len - 1, rdata});
        if (pushed == bad_resp || pushed == bad_last) begin
          exp_err = 1'b1;
          if (err_burst < 0) err_burst = ar_idx - 1;
        end
        pushed++;
        beats_left--;
        r_taken = 1'b1;
      end
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("dout_extra", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("dout_data", dout, e[31:0]);
          check_eq("dout_last", dout_last, e[32]);
        end
        popped++;
        last_hs = cyc;
      end
      n_allowed = (err_burst >= 0) ? err_burst + 1 : exp_ar_addr.size();
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_pulses", done_cnt, 1);
        check_eq("done_timing", cyc, last_hs + 1);
        check_eq("err_at_done", err, exp_err);
        check_eq("words_left", exp_q.size(), 0);
        check_eq("word_count", popped, exp_err ? pushed : len);
        check_eq("ar_count", ar_idx, n_allowed);
        if (exp_done_cyc >= 0) check_eq("done_cycle", cyc, exp_done_cyc);
      end else if (done_cnt > 0 && cyc == done_cyc + 1) begin
        check_eq("busy_after_done", busy, 1'b0);
        check_eq("err_sticky", err, exp_err);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!finished) check_eq("timeout", 1'b0, 1'b1);
    rvalid = 1'b0; arready = 1'b0; dout_rdy = 1'b0; start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; src_addr = '0; len_words = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    dout_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctl", {busy, done, err, arvalid, rready, dout_vld, dout_last}, 7'd0);
    check_eq("rst_addr", {araddr, arlen}, 36'd0);
    check_eq("rst_dout", dout, 32'd0);
    rstn = 1'b1;

    //        addr          len ar   rv   rdy  bresp blast bs  abort done
    run_xfer(32'h0000_1000,  4, 100, 100, 100, -1,   -1,   0,  0,    6);
    run_xfer(32'h0000_0000, 40, 100, 100, 100, -1,   -1,   0,  0,   -1);
    run_xfer(32'h0000_0FF8,  4, 100, 100, 100, -1,   -1,   0,  0,   -1);
    run_xfer(32'h0000_2000, 16, 100, 100, 100,  3,   -1,   0,  0,   -1);
    run_xfer(32'h0000_3004, 20, 100, 100,   0, -1,   -1,   0,  0,   -1);
    run_xfer(32'h0000_4000,  0, 100, 100, 100, -1,   -1,   0,  0,    0);
    run_xfer(32'h0000_5000, 30,  60,  70,  50, -1,   -1,   1,  0,   -1);
    run_xfer(32'h0000_6000,  8, 100, 100, 100, -1,    7,   0,  0,   -1);
    run_xfer(32'h0000_7000, 20, 100, 100, 100, -1,    2,   0,  0,   -1);
    run_xfer(32'h0000_8000, 40, 100, 100, 100, -1,   -1,   0, 12,   -1);
    run_xfer(32'h0000_9FF0, 10, 100, 100, 100, -1,   -1,   0,  0,   -1);

    for (int t = 0; t < 30; t++) begin
      int unsigned a;
      int l, br, bl;
      a  = $urandom_range(1, 255) * 4096 - 4 * $urandom_range(0, 24) + $urandom_range(0, 3);
      l  = $urandom_range(0, 70);
      br = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : -1;
      bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : -1;
      run_xfer(a, l, $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(20, 100), br, bl, (br < 0 && bl < 0), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
